pong_engine: RTL and testbench

Parametrised game core for the VGA Pong design: debounced paddle control, a bouncing ball with wall/paddle collision, a serve/play/miss state machine, and registered RGB pixel output. Sits between the sync generator (which supplies pixel counters, display-enable and a per-frame tick) and the VGA pins. All game state advances once per frame tick; pixel colour is computed every clock.

---
 rtl/pong_engine.sv | 242 ++++++++++++++++++++++++
 tb/tb_pong_engine.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pong_engine.sv
// Pong game core: debounced paddle, bouncing ball, SERVE/PLAY/MISS FSM, registered RGB.
// Optional PONG_SCORE_EN adds the miss_count port and a white paddle flash on each hit.

module pong_debounce #(
  parameter int W = 16
)(
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic level
);
  logic [1:0]   sync;
  logic [W-1:0] cnt;

  // The level flips only after 2^W consecutive samples that disagree with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], ~btn_n};
      if (sync[1] == level) cnt <= '0;
      else if (&cnt) begin
        cnt   <= '0;
        level <= sync[1];
      end else cnt <= cnt + W'(1);
    end
  end
endmodule

module pong_engine #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int PADDLE_W    = 96,
  parameter int PADDLE_Y    = 320,
  parameter int PADDLE_H    = 8,
  parameter int PADDLE_STEP = 4,
  parameter int BALL_SIZE   = 8,
  parameter int BALL_SPEED  = 2,
  parameter int DEBOUNCE    = 16,
  parameter int MISS_FRAMES = 60
)(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic [9:0] counter_x,
  input  logic [9:0] counter_y,
  input  logic       in_display_area,
  input  logic       button_left,
  input  logic       button_right,
  output logic       vga_r,
  output logic       vga_g,
  output logic       vga_b,
  output logic [9:0] paddle_x,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [1:0] game_state
`ifdef PONG_SCORE_EN
  ,
  output logic [7:0] miss_count
`endif
);
  typedef enum logic [1:0] {SERVE = 2'd0, PLAY = 2'd1, MISS = 2'd2} state_t;

  localparam int MFW = (MISS_FRAMES > 2) ? $clog2(MISS_FRAMES) : 1;
  localparam logic [9:0] PAD_RST = 10'((H_ACTIVE - PADDLE_W) / 2);
  localparam logic [9:0] SERVE_X = 10'(H_ACTIVE / 2 - BALL_SIZE / 2);
  localparam logic [9:0] SERVE_Y = 10'(V_ACTIVE / 4);
  localparam logic signed [10:0] PAD_MAX = 11'(H_ACTIVE - PADDLE_W);
  localparam logic signed [10:0] X_MAX   = 11'(H_ACTIVE - BALL_SIZE);
  localparam logic signed [10:0] STEP    = 11'(PADDLE_STEP);
  localparam logic signed [10:0] SPD     = 11'(BALL_SPEED);
  localparam logic signed [10:0] BSZ     = 11'(BALL_SIZE);
  localparam logic signed [10:0] PW      = 11'(PADDLE_W);
  localparam logic signed [10:0] PY      = 11'(PADDLE_Y);
  localparam logic signed [10:0] VMAX    = 11'(V_ACTIVE);
  localparam logic [10:0] PIX_BW = 11'(BALL_SIZE);
  localparam logic [10:0] PIX_PW = 11'(PADDLE_W);
  localparam logic [10:0] PIX_PY = 11'(PADDLE_Y);
  localparam logic [10:0] PIX_PH = 11'(PADDLE_H);

  // buttons: [0]=left, [1]=right, active-high after debounce
  logic [1:0] btn_n, btn_db;
  assign btn_n = {button_right, button_left};

  for (genvar g = 0; g < 2; g++) begin : g_db
    pong_debounce #(.W(DEBOUNCE)) u_db (
      .clk(clk), .rst_n(rst_n), .btn_n(btn_n[g]), .level(btn_db[g])
    );
  end

  state_t          state_q, state_d;
  logic            dx, dy, serve_dir;
  logic [MFW-1:0]  miss_frm;
  logic            hit, lost;
  logic [9:0]      pad_nxt, bx_nxt, by_nxt;
  logic            dx_nxt, dy_nxt;
  logic signed [10:0] pad_s, pad_l, pad_r, bx_s, by_s, nx, ny;
`ifdef PONG_SCORE_EN
  logic [2:0] flash;
`endif

  // paddle step with clamp; signed math keeps the left edge from wrapping
  always_comb begin
    pad_s   = $signed({1'b0, paddle_x});
    pad_l   = pad_s - STEP;
    pad_r   = pad_s + STEP;
    pad_nxt = paddle_x;
    case (btn_db)
      2'b01:   pad_nxt = (pad_l < 11'sd0)  ? 10'd0        : pad_l[9:0];
      2'b10:   pad_nxt = (pad_r > PAD_MAX) ? PAD_MAX[9:0] : pad_r[9:0];
      default: pad_nxt = paddle_x;
    endcase
  end

  // ball step; paddle overlap uses the pre-tick paddle position
  always_comb begin
    bx_s   = $signed({1'b0, ball_x});
    by_s   = $signed({1'b0, ball_y});
    nx     = dx ? bx_s + SPD : bx_s - SPD;
    ny     = dy ? by_s + SPD : by_s - SPD;
    dx_nxt = dx;
    dy_nxt = dy;
    hit    = 1'b0;
    lost   = 1'b0;
    if (nx <= 11'sd0) begin
      bx_nxt = 10'd0;
      dx_nxt = 1'b1;
    end else if (nx >= X_MAX) begin
      bx_nxt = X_MAX[9:0];
      dx_nxt = 1'b0;
    end else bx_nxt = nx[9:0];
    by_nxt = ny[9:0];
    if (!dy) begin
      if (ny <= 11'sd0) begin
        by_nxt = 10'd0;
        dy_nxt = 1'b1;
      end
    end else begin
      hit = (by_s + BSZ < PY) && (ny + BSZ >= PY) &&
            (bx_s < pad_s + PW) && (bx_s + BSZ > pad_s);
      if (hit) begin
        by_nxt = 10'(PY - BSZ);
        dy_nxt = 1'b0;
      end else if (ny >= VMAX) lost = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SERVE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (frame_tick) begin
      case (state_q)
        SERVE:   if (|btn_db) state_d = PLAY;
        PLAY:    if (lost) state_d = MISS;
        MISS:    if (miss_frm == MFW'(MISS_FRAMES - 1)) state_d = SERVE;
        default: state_d = SERVE;
      endcase
    end
  end

  always_comb game_state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      paddle_x  <= PAD_RST;
      ball_x    <= SERVE_X;
      ball_y    <= SERVE_Y;
      dx        <= 1'b1;
      dy        <= 1'b1;
      serve_dir <= 1'b1;
      miss_frm  <= '0;
`ifdef PONG_SCORE_EN
      miss_count <= '0;
      flash      <= '0;
`endif
    end else if (frame_tick) begin
      paddle_x <= pad_nxt;
`ifdef PONG_SCORE_EN
      if (flash != 3'd0) flash <= flash - 3'd1;
`endif
      case (state_q)
        SERVE: if (state_d == PLAY) serve_dir <= ~serve_dir;
        PLAY: begin
          ball_x <= bx_nxt;
          ball_y <= by_nxt;
          dx     <= dx_nxt;
          dy     <= dy_nxt;
`ifdef PONG_SCORE_EN
          if (hit) flash <= 3'd4;
          if (lost && miss_count != 8'hFF) miss_count <= miss_count + 8'd1;
`endif
        end
        MISS: begin
          if (state_d == SERVE) begin
            miss_frm <= '0;
            ball_x   <= SERVE_X;
            ball_y   <= SERVE_Y;
            dx       <= serve_dir;
            dy       <= 1'b1;
          end else miss_frm <= miss_frm + MFW'(1);
        end
        default: ;
      endcase
    end
  end

  // pixel colour, one clock behind the counters
  logic [10:0] cx, cy, bxp, byp, pxp;
  logic        in_ball, in_pad, pad_white;
  logic [2:0]  rgb_d;

  always_comb begin
    cx      = {1'b0, counter_x};
    cy      = {1'b0, counter_y};
    bxp     = {1'b0, ball_x};
    byp     = {1'b0, ball_y};
    pxp     = {1'b0, paddle_x};
    in_ball = (cx >= bxp) && (cx < bxp + PIX_BW) && (cy >= byp) && (cy < byp + PIX_BW);
    in_pad  = (cx >= pxp) && (cx < pxp + PIX_PW) && (cy >= PIX_PY) && (cy < PIX_PY + PIX_PH);
`ifdef PONG_SCORE_EN
    pad_white = (flash != 3'd0);
`else
    pad_white = 1'b0;
`endif
    if (!in_display_area)   rgb_d = 3'b000;
    else if (in_ball)       rgb_d = 3'b111;
    else if (in_pad)        rgb_d = pad_white ? 3'b111 : 3'b010;
    else if (state_q == MISS) rgb_d = 3'b100;
    else                    rgb_d = 3'b000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {vga_r, vga_g, vga_b} <= 3'b000;
    else        {vga_r, vga_g, vga_b} <= rgb_d;
  end
endmodule

// File: tb/tb_pong_engine.sv
// Directed bench for pong_engine: reset, pixels, debounce, paddle clamp, wall/paddle bounce, miss cycle.
module tb_pong_engine;
  logic       clk = 1'b0, rst_n = 1'b0, frame_tick = 1'b0, in_display_area = 1'b0;
  logic [9:0] counter_x = '0, counter_y = '0;
  logic       button_left = 1'b1, button_right = 1'b1;
  logic       vga_r, vga_g, vga_b;
  logic [9:0] paddle_x, ball_x, ball_y;
  logic [1:0] game_state;
`ifdef PONG_SCORE_EN
  logic [7:0] miss_count;
  localparam int FLASH_RGB = 7;
`else
  localparam int FLASH_RGB = 2;
`endif

  int n_run = 0, n_fail = 0;

  always #5 clk = ~clk;

  pong_engine #(.DEBOUNCE(3)) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .counter_x(counter_x), .counter_y(counter_y), .in_display_area(in_display_area),
    .button_left(button_left), .button_right(button_right),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .paddle_x(paddle_x), .ball_x(ball_x), .ball_y(ball_y), .game_state(game_state)
`ifdef PONG_SCORE_EN
    , .miss_count(miss_count)
`endif
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_run++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic pix(input string tag, input int x, input int y, input logic de, input int exp);
    counter_x = 10'(x);
    counter_y = 10'(y);
    in_display_area = de;
    @(posedge clk); #1;
    chk(tag, int'({vga_r, vga_g, vga_b}), exp);
    in_display_area = 1'b0;
  endtask

  initial begin
    clks(3);
    chk("rst_paddle", paddle_x, 272);
    chk("rst_ball_x", ball_x, 316);
    chk("rst_ball_y", ball_y, 120);
    chk("rst_state", game_state, 0);
    chk("rst_rgb", int'({vga_r, vga_g, vga_b}), 0);
    rst_n = 1'b1;
    clks(2);

    pix("pix_ball", 320, 124, 1'b1, 7);
    pix("pix_paddle", 272, 320, 1'b1, 2);
    pix("pix_bg", 0, 0, 1'b1, 0);
    pix("pix_blank", 320, 124, 1'b0, 0);

    // short glitch must not register as a press
    button_left = 1'b0; clks(5); button_left = 1'b1; clks(20);
    tick();
    chk("glitch_paddle", paddle_x, 272);
    chk("glitch_state", game_state, 0);

    // stable press: serves and moves paddle left
    button_left = 1'b0; clks(20);
    tick();
    chk("press_paddle", paddle_x, 268);
    chk("serve_state", game_state, 1);
    chk("serve_ball_x", ball_x, 316);
    button_left = 1'b1; clks(20);

    // round 1: ball heads right/down, paddle at 268 misses it
    tick();
    chk("t1_x", ball_x, 318);
    chk("t1_y", ball_y, 122);
    chk("t1_paddle", paddle_x, 268);
    ticks(95);
    chk("t96_y", ball_y, 312);
    tick();
    chk("pass_thru_y", ball_y, 314);
    ticks(60);
    chk("t157_x", ball_x, 630);
    tick();
    chk("rwall_x", ball_x, 632);
    tick();
    chk("rwall_bounce_x", ball_x, 630);
    ticks(20);
    chk("t179_state", game_state, 1);
    chk("t179_y", ball_y, 478);
    tick();
    chk("miss_state", game_state, 2);
`ifdef PONG_SCORE_EN
    chk("miss_count1", miss_count, 1);
`endif
    pix("pix_miss_bg", 0, 0, 1'b1, 4);

    // both held through MISS: paddle holds
    button_left = 1'b0; button_right = 1'b0; clks(20);
    ticks(59);
    chk("miss59_state", game_state, 2);
    chk("both_paddle", paddle_x, 268);
    tick();
    chk("reserve_state", game_state, 0);
    chk("reserve_x", ball_x, 316);
    chk("reserve_y", ball_y, 120);
    tick();
    chk("serve2_state", game_state, 1);
    chk("serve2_paddle", paddle_x, 268);

    // round 2: ball heads left; park paddle at 100 under it
    button_right = 1'b1; clks(20);
    ticks(42);
    chk("left42_paddle", paddle_x, 100);
    chk("r2_t42_x", ball_x, 232);
    button_left = 1'b1; clks(20);
    ticks(54);
    chk("hit_y", ball_y, 312);
    chk("hit_state", game_state, 1);
    pix("pix_hit_paddle", 100, 320, 1'b1, FLASH_RGB);
    tick();
    chk("hit_up_y", ball_y, 310);
    ticks(60);
    chk("t157_x2", ball_x, 2);
    tick();
    chk("lwall_x", ball_x, 0);
    tick();
    chk("lwall_bounce_x", ball_x, 2);
    ticks(92);
    chk("t251_y", ball_y, 2);
    tick();
    chk("top_y", ball_y, 0);
    tick();
    chk("top_bounce_y", ball_y, 2);
`ifdef PONG_SCORE_EN
    chk("miss_count_hold", miss_count, 1);
`endif

    // paddle clamps at both edges
    button_right = 1'b0; clks(20);
    ticks(120);
    chk("clamp_right", paddle_x, 544);
    button_right = 1'b1; button_left = 1'b0; clks(20);
    ticks(140);
    chk("clamp_left", paddle_x, 0);
    button_left = 1'b1; clks(20);

    // asynchronous reset mid-game
    counter_x = 10'd10; counter_y = 10'd320; in_display_area = 1'b1;
    @(posedge clk); #1;
    chk("pre_rst_g", int'(vga_g), 1);
    rst_n = 1'b0; #1;
    chk("arst_rgb", int'({vga_r, vga_g, vga_b}), 0);
    chk("arst_paddle", paddle_x, 272);
    chk("arst_ball_x", ball_x, 316);
    chk("arst_ball_y", ball_y, 120);
    chk("arst_state", game_state, 0);
    in_display_area = 1'b0;
    tick();
    chk("rst_tick_paddle", paddle_x, 272);
    rst_n = 1'b1;
    clks(2);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
